// File: rtl/go_debouncer.sv
// ---------------------------------------------------------------------------
// go_debouncer
//   Conditions the raw asynchronous "Go" pushbutton into a clean, debounced
//   level in the clock domain. One accepted press produces exactly one rising
//   edge on Go, so the downstream move-store FSM stores a move exactly once.
//
// Ports
//   clock        in   1  system clock, all state on posedge
//   reset_b      in   1  asynchronous reset, active-high (asserted = 1)
//   button_raw   in   1  raw pushbutton level, asynchronous, may bounce
//   Go           out  1  debounced button level (direct state-register bit)
//   press_count  out  8  accepted-press counter
//
// Parameters
//   SYNC_STAGES      synchroniser depth on button_raw (>= 2)
//   DEBOUNCE_CYCLES  stable synchronised cycles needed to accept a change (>= 2)
//
// Build option
//   GO_DEBOUNCE_PRESS_COUNT_EN  when defined, press_count counts accepted
//                               presses (wrapping at 8 bits); otherwise it is
//                               tied to 8'h00 and no counter flops exist.
// ---------------------------------------------------------------------------
module go_debouncer #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset_b,
  input  logic       button_raw,
  output logic       Go,
  output logic [7:0] press_count
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit 1 of the encoding is the Go level, so Go comes straight off a flop.
  typedef enum logic [1:0] {
    ST_IDLE         = 2'b00,
    ST_PRESS_WAIT   = 2'b01,
    ST_PRESSED      = 2'b10,
    ST_RELEASE_WAIT = 2'b11
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  state_t                 w_next_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_next_cnt;
  logic                   w_s;

  // Synchroniser: button_raw only ever reaches the first flop.
  always_ff @(posedge clock or posedge reset_b) begin
    if (reset_b) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], button_raw};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // State and stability-counter registers.
  always_ff @(posedge clock or posedge reset_b) begin
    if (reset_b) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Next-state logic; the counter saturates at CNT_LAST because reaching it
  // always leaves the wait state.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_s) begin
          w_next_state = ST_PRESS_WAIT;
          w_next_cnt   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!w_s) begin
          w_next_state = ST_IDLE;
          w_next_cnt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_next_state = ST_PRESSED;
        end else begin
          w_next_cnt = r_cnt + CNT_W'(1);
        end
      end
      ST_PRESSED: begin
        if (!w_s) begin
          w_next_state = ST_RELEASE_WAIT;
          w_next_cnt   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (w_s) begin
          w_next_state = ST_PRESSED;
          w_next_cnt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_cnt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  assign Go = r_state[1];

`ifdef GO_DEBOUNCE_PRESS_COUNT_EN
  logic       w_press_accept;
  logic [7:0] r_press_count;

  assign w_press_accept = (r_state == ST_PRESS_WAIT) && (w_next_state == ST_PRESSED);

  // Accepted-press counter; wraps naturally at 8 bits.
  always_ff @(posedge clock or posedge reset_b) begin
    if (reset_b) begin
      r_press_count <= 8'h00;
    end else if (w_press_accept) begin
      r_press_count <= r_press_count + 8'd1;
    end
  end

  assign press_count = r_press_count;
`else
  assign press_count = 8'h00;
`endif

endmodule

// File: tb/tb_go_debouncer.sv
// ---------------------------------------------------------------------------
// tb_go_debouncer
//   Self-checking bench for go_debouncer (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
//   A run-length model predicts {Go, press_count} for every clock edge; the
//   prediction is queued when the input is driven and compared after the edge.
// ---------------------------------------------------------------------------
module tb_go_debouncer;

  localparam int unsigned SYNC   = 2;
  localparam int unsigned DEB    = 4;
  // Go flips on the edge where this many consecutive synchronised samples
  // disagree with it (one IDLE/PRESSED sample plus DEB wait samples).
  localparam int unsigned THRESH = DEB + 1;

`ifdef GO_DEBOUNCE_PRESS_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clock;
  logic       reset_b;
  logic       button_raw;
  logic       Go;
  logic [7:0] press_count;

  int errors = 0;
  int checks = 0;

  logic [8:0] exp_q[$];

  logic [SYNC-1:0] m_sync;
  logic            m_go;
  int              m_run;
  logic [7:0]      m_cnt;
  logic            prev_go;
  int              obs_rises;

  go_debouncer #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clock      (clock),
    .reset_b    (reset_b),
    .button_raw (button_raw),
    .Go         (Go),
    .press_count(press_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_reset();
    m_sync  = '0;
    m_go    = 1'b0;
    m_run   = 0;
    m_cnt   = 8'h00;
    prev_go = 1'b0;
  endtask

  // One clock cycle: drive at negedge, predict, compare 1 ns after posedge.
  task automatic drive_cycle(input logic raw);
    logic       s_seen;
    logic [8:0] exp;
    @(negedge clock);
    button_raw = raw;
    s_seen = m_sync[SYNC-1];
    m_sync = {m_sync[SYNC-2:0], raw};
    if (s_seen != m_go) begin
      m_run++;
      if (m_run == int'(THRESH)) begin
        m_go  = s_seen;
        m_run = 0;
        if (m_go && CNT_EN) m_cnt = m_cnt + 8'd1;
      end
    end else begin
      m_run = 0;
    end
    exp_q.push_back({m_go, m_cnt});
    @(posedge clock);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if ({Go, press_count} !== exp) begin
      errors++;
      $display("FAIL scoreboard t=%0t got Go=%b cnt=%02h, expected Go=%b cnt=%02h",
               $time, Go, press_count, exp[8], exp[7:0]);
    end
    if (Go === 1'b1 && prev_go === 1'b0) obs_rises++;
    prev_go = Go;
  endtask

  task automatic drive_n(input logic raw, input int n);
    for (int i = 0; i < n; i++) drive_cycle(raw);
  endtask

  // Assert reset between clock edges and verify outputs clear with no edge.
  task automatic reset_now(input string tag);
    #2;
    reset_b = 1'b1;
    model_reset();
    #1;
    checks++;
    if (Go !== 1'b0 || press_count !== 8'h00) begin
      errors++;
      $display("FAIL %s got Go=%b cnt=%02h, expected Go=0 cnt=00", tag, Go, press_count);
    end
    repeat (2) @(posedge clock);
    #1;
    reset_b = 1'b0;
  endtask

  task automatic test_reset();
    reset_b    = 1'b1;
    button_raw = 1'b0;
    model_reset();
    #1;
    checks++;
    if (Go !== 1'b0 || press_count !== 8'h00) begin
      errors++;
      $display("FAIL reset_initial got Go=%b cnt=%02h, expected Go=0 cnt=00", Go, press_count);
    end
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (Go !== 1'b0 || press_count !== 8'h00) begin
      errors++;
      $display("FAIL reset_held got Go=%b cnt=%02h, expected Go=0 cnt=00", Go, press_count);
    end
    reset_b = 1'b0;
  endtask

  task automatic test_clean_press();
    logic [7:0] want_cnt;
    want_cnt = CNT_EN ? 8'd1 : 8'd0;
    drive_n(1'b0, 3);
    drive_n(1'b1, 20);
    checks++;
    if (Go !== 1'b1 || press_count !== want_cnt) begin
      errors++;
      $display("FAIL clean_press got Go=%b cnt=%02h, expected Go=1 cnt=%02h",
               Go, press_count, want_cnt);
    end
    drive_n(1'b0, 10);
  endtask

  task automatic test_bounce();
    int         rises0;
    logic [7:0] cnt0;
    rises0 = obs_rises;
    cnt0   = press_count;
    for (int r = 0; r < 4; r++) begin
      drive_n(1'b1, 3);
      drive_cycle(1'b0);
    end
    drive_n(1'b0, 8);
    checks++;
    if (obs_rises != rises0 || Go !== 1'b0 || press_count !== cnt0) begin
      errors++;
      $display("FAIL bounce got rises=%0d Go=%b cnt=%02h, expected rises=%0d Go=0 cnt=%02h",
               obs_rises - rises0, Go, press_count, 0, cnt0);
    end
  endtask

  task automatic test_release_bounce();
    drive_n(1'b1, 10);
    drive_n(1'b0, 2);
    drive_cycle(1'b1);
    drive_n(1'b0, 10);
    checks++;
    if (Go !== 1'b0) begin
      errors++;
      $display("FAIL release_bounce got Go=%b, expected Go=0", Go);
    end
  endtask

  task automatic test_reset_mid();
    drive_n(1'b1, 5);
    reset_now("reset_press_wait");
    drive_n(1'b1, 10);
    reset_now("reset_pressed");
    drive_n(1'b0, 6);
  endtask

  task automatic test_held_through_reset();
    @(negedge clock);
    button_raw = 1'b1;
    reset_now("reset_held_entry");
    obs_rises = 0;
    drive_n(1'b1, 14);
    checks++;
    if (obs_rises != 1 || Go !== 1'b1) begin
      errors++;
      $display("FAIL held_through_reset got rises=%0d Go=%b, expected rises=1 Go=1",
               obs_rises, Go);
    end
    drive_n(1'b0, 10);
  endtask

  task automatic test_wrap();
    reset_now("reset_before_wrap");
    obs_rises = 0;
    for (int p = 0; p < 256; p++) begin
      drive_n(1'b1, 8);
      drive_n(1'b0, 8);
      if (p == 254) begin
        checks++;
        if (press_count !== (CNT_EN ? 8'hFF : 8'h00)) begin
          errors++;
          $display("FAIL wrap_255 got cnt=%02h, expected %02h",
                   press_count, CNT_EN ? 8'hFF : 8'h00);
        end
      end
    end
    checks++;
    if (press_count !== 8'h00 || obs_rises != 256) begin
      errors++;
      $display("FAIL wrap_256 got cnt=%02h rises=%0d, expected cnt=00 rises=256",
               press_count, obs_rises);
    end
  endtask

  initial begin
    obs_rises = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_reset_mid();
    test_held_through_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
